// File: rtl/lwc_block_buffer_if.sv
// Bus bundle for lwc_block_buffer: bdi input words, assembled block towards
// the cipher core, result block from the core and bdo output words.
// slave = the buffer itself, master = the surrounding pre/post-processor + core.
interface lwc_block_buffer_if #(
  parameter int W           = 32,
  parameter int BLOCK_WORDS = 8
);
  localparam int NB = W / 8;
  localparam int BB = $clog2(NB * BLOCK_WORDS) + 1;

  logic [W-1:0]             bdi;
  logic                     bdi_valid;
  logic                     bdi_ready;
  logic                     bdi_eot;
  logic [NB-1:0]            bdi_valid_bytes;
  logic [W*BLOCK_WORDS-1:0] blk_data;
  logic [BB-1:0]            blk_bytes;
  logic                     blk_last;
  logic                     blk_valid;
  logic                     blk_ready;
  logic [W*BLOCK_WORDS-1:0] res_data;
  logic [BB-1:0]            res_bytes;
  logic                     res_valid;
  logic                     res_ready;
  logic [W-1:0]             bdo;
  logic                     bdo_valid;
  logic                     bdo_ready;
  logic [NB-1:0]            bdo_valid_bytes;
  logic                     end_of_block;

  modport slave (
    input  bdi, bdi_valid, bdi_eot, bdi_valid_bytes,
    output bdi_ready,
    output blk_data, blk_bytes, blk_last, blk_valid,
    input  blk_ready,
    input  res_data, res_bytes, res_valid,
    output res_ready,
    output bdo, bdo_valid, bdo_valid_bytes, end_of_block,
    input  bdo_ready
  );

  modport master (
    output bdi, bdi_valid, bdi_eot, bdi_valid_bytes,
    input  bdi_ready,
    input  blk_data, blk_bytes, blk_last, blk_valid,
    output blk_ready,
    output res_data, res_bytes, res_valid,
    input  res_ready,
    input  bdo, bdo_valid, bdo_valid_bytes, end_of_block,
    output bdo_ready
  );
endinterface

// File: rtl/lwc_block_buffer.sv
// lwc_block_buffer: packs bdi words into a padded block for the cipher core
// and serialises result blocks back onto bdo with byte masks.
// Optional feature macro: LWC_OUT_PINGPONG_EN (two result buffers, no bubble
// between consecutive results). Default build uses a single result buffer.
module lwc_block_buffer #(
  parameter int          W           = 32,
  parameter int          BLOCK_WORDS = 8,
  parameter logic [7:0]  PAD_BYTE    = 8'h01
) (
  input  logic              clk,
  input  logic              rst,
  lwc_block_buffer_if.slave bus
);
  localparam int NB  = W / 8;
  localparam int BB  = $clog2(NB * BLOCK_WORDS) + 1;
  localparam int WCW = $clog2(BLOCK_WORDS);

  // ---------------- input side ----------------
  typedef enum logic {FILL, FULL} in_state_t;

  in_state_t                in_state_reg, in_state_next;
  logic [WCW-1:0]           wcnt_reg, wcnt_next;
  logic [BB-1:0]            blk_bytes_reg, blk_bytes_next;
  logic                     blk_last_reg, blk_last_next;
  logic [W*BLOCK_WORDS-1:0] blk_data_reg, blk_data_next;
  logic [W-1:0]             word_fill;
  logic [BB-1:0]            in_cnt;
  logic                     in_full_mask;
  logic                     in_last_slot;

  // Number of valid bytes in the incoming word (mask is contiguous MSB-first).
  always_comb begin
    in_cnt = '0;
    for (int i = 0; i < NB; i++) in_cnt = in_cnt + BB'(bus.bdi_valid_bytes[i]);
  end

  // Invalid bytes are zeroed; the first invalid byte receives the pad.
  genvar gi;
  for (gi = 0; gi < NB; gi++) begin : g_in_byte
    assign word_fill[W-1-8*gi -: 8] = bus.bdi_valid_bytes[NB-1-gi] ? bus.bdi[W-1-8*gi -: 8] :
                                      (in_cnt == BB'(gi)) ? PAD_BYTE : 8'h00;
  end

  assign in_full_mask = &bus.bdi_valid_bytes;
  assign in_last_slot = (wcnt_reg == WCW'(BLOCK_WORDS - 1));

  // Input FSM next state: slot write, pad placement and block handover.
  always_comb begin
    in_state_next  = in_state_reg;
    wcnt_next      = wcnt_reg;
    blk_bytes_next = blk_bytes_reg;
    blk_last_next  = blk_last_reg;
    blk_data_next  = blk_data_reg;
    case (in_state_reg)
      FILL: begin
        if (bus.bdi_valid) begin
          blk_bytes_next = blk_bytes_reg + in_cnt;
          for (int k = 0; k < BLOCK_WORDS; k++) begin
            if (32'(wcnt_reg) == k)
              blk_data_next[W*(BLOCK_WORDS-k)-1 -: W] = word_fill;
            // A full final word that ends short of the block: pad opens the next slot.
            if (bus.bdi_eot && !in_last_slot && in_full_mask && (32'(wcnt_reg) + 1 == k))
              blk_data_next[W*(BLOCK_WORDS-k)-1 -: 8] = PAD_BYTE;
          end
          if (in_last_slot || bus.bdi_eot) begin
            in_state_next = FULL;
            blk_last_next = bus.bdi_eot;
          end else begin
            wcnt_next = wcnt_reg + WCW'(1);
          end
        end
      end
      FULL: begin
        if (bus.blk_ready) begin
          in_state_next  = FILL;
          wcnt_next      = '0;
          blk_bytes_next = '0;
          blk_last_next  = 1'b0;
          blk_data_next  = '0;
        end
      end
      default: in_state_next = FILL;
    endcase
  end

  // Input state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_state_reg  <= FILL;
      wcnt_reg      <= '0;
      blk_bytes_reg <= '0;
      blk_last_reg  <= 1'b0;
      blk_data_reg  <= '0;
    end else begin
      in_state_reg  <= in_state_next;
      wcnt_reg      <= wcnt_next;
      blk_bytes_reg <= blk_bytes_next;
      blk_last_reg  <= blk_last_next;
      blk_data_reg  <= blk_data_next;
    end
  end

  assign bus.bdi_ready = (in_state_reg == FILL);
  assign bus.blk_valid = (in_state_reg == FULL);
  assign bus.blk_data  = blk_data_reg;
  assign bus.blk_bytes = blk_bytes_reg;
  assign bus.blk_last  = blk_last_reg;

  // ---------------- output side ----------------
  logic [BB-1:0]            res_nwords;
  logic [WCW-1:0]           res_last_idx;
  logic [WCW-1:0]           ocnt_reg, ocnt_next;
  logic [W*BLOCK_WORDS-1:0] cur_data;
  logic [BB-1:0]            cur_bytes;
  logic [WCW-1:0]           cur_last;
  logic                     out_active;

  assign res_nwords   = BB'((32'(bus.res_bytes) + NB - 1) / NB);
  assign res_last_idx = WCW'(res_nwords - BB'(1));

`ifdef LWC_OUT_PINGPONG_EN
  logic [1:0]               pp_full_reg, pp_full_next;
  logic [W*BLOCK_WORDS-1:0] pp_data_reg [2];
  logic [W*BLOCK_WORDS-1:0] pp_data_next [2];
  logic [BB-1:0]            pp_bytes_reg [2];
  logic [BB-1:0]            pp_bytes_next [2];
  logic [WCW-1:0]           pp_last_reg [2];
  logic [WCW-1:0]           pp_last_next [2];
  logic                     wr_ptr_reg, wr_ptr_next, rd_ptr_reg, rd_ptr_next;
  logic                     res_ready_c;

  // Two-entry in-order result store: capture at wr_ptr, drain from rd_ptr.
  always_comb begin
    pp_full_next  = pp_full_reg;
    pp_data_next  = pp_data_reg;
    pp_bytes_next = pp_bytes_reg;
    pp_last_next  = pp_last_reg;
    wr_ptr_next   = wr_ptr_reg;
    rd_ptr_next   = rd_ptr_reg;
    ocnt_next     = ocnt_reg;
    res_ready_c   = !pp_full_reg[wr_ptr_reg];
    if (res_ready_c && bus.res_valid && (res_nwords != '0)) begin
      pp_full_next[wr_ptr_reg]  = 1'b1;
      pp_data_next[wr_ptr_reg]  = bus.res_data;
      pp_bytes_next[wr_ptr_reg] = bus.res_bytes;
      pp_last_next[wr_ptr_reg]  = res_last_idx;
      wr_ptr_next               = ~wr_ptr_reg;
    end
    if (pp_full_reg[rd_ptr_reg] && bus.bdo_ready) begin
      if (ocnt_reg == pp_last_reg[rd_ptr_reg]) begin
        pp_full_next[rd_ptr_reg] = 1'b0;
        rd_ptr_next              = ~rd_ptr_reg;
        ocnt_next                = '0;
      end else begin
        ocnt_next = ocnt_reg + WCW'(1);
      end
    end
  end

  // Ping-pong buffer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pp_full_reg  <= '0;
      pp_data_reg  <= '{default: '0};
      pp_bytes_reg <= '{default: '0};
      pp_last_reg  <= '{default: '0};
      wr_ptr_reg   <= 1'b0;
      rd_ptr_reg   <= 1'b0;
      ocnt_reg     <= '0;
    end else begin
      pp_full_reg  <= pp_full_next;
      pp_data_reg  <= pp_data_next;
      pp_bytes_reg <= pp_bytes_next;
      pp_last_reg  <= pp_last_next;
      wr_ptr_reg   <= wr_ptr_next;
      rd_ptr_reg   <= rd_ptr_next;
      ocnt_reg     <= ocnt_next;
    end
  end

  assign bus.res_ready = res_ready_c;
  assign cur_data      = pp_data_reg[rd_ptr_reg];
  assign cur_bytes     = pp_bytes_reg[rd_ptr_reg];
  assign cur_last      = pp_last_reg[rd_ptr_reg];
  assign out_active    = pp_full_reg[rd_ptr_reg];
`else
  typedef enum logic {IDLE, SEND} out_state_t;

  out_state_t               out_state_reg, out_state_next;
  logic [W*BLOCK_WORDS-1:0] res_data_reg, res_data_next;
  logic [BB-1:0]            res_bytes_reg, res_bytes_next;
  logic [WCW-1:0]           last_idx_reg, last_idx_next;
  logic                     res_ready_c;

  // Output FSM: capture a result in IDLE, walk its words in SEND.
  always_comb begin
    out_state_next = out_state_reg;
    res_data_next  = res_data_reg;
    res_bytes_next = res_bytes_reg;
    last_idx_next  = last_idx_reg;
    ocnt_next      = ocnt_reg;
    res_ready_c    = (out_state_reg == IDLE);
    case (out_state_reg)
      IDLE: begin
        if (bus.res_valid) begin
          res_data_next  = bus.res_data;
          res_bytes_next = bus.res_bytes;
          last_idx_next  = res_last_idx;
          ocnt_next      = '0;
          // An empty result is swallowed without producing any bdo word.
          if (res_nwords != '0) out_state_next = SEND;
        end
      end
      SEND: begin
        if (bus.bdo_ready) begin
          if (ocnt_reg == last_idx_reg) begin
            out_state_next = IDLE;
            ocnt_next      = '0;
          end else begin
            ocnt_next = ocnt_reg + WCW'(1);
          end
        end
      end
      default: out_state_next = IDLE;
    endcase
  end

  // Single result buffer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_state_reg <= IDLE;
      res_data_reg  <= '0;
      res_bytes_reg <= '0;
      last_idx_reg  <= '0;
      ocnt_reg      <= '0;
    end else begin
      out_state_reg <= out_state_next;
      res_data_reg  <= res_data_next;
      res_bytes_reg <= res_bytes_next;
      last_idx_reg  <= last_idx_next;
      ocnt_reg      <= ocnt_next;
    end
  end

  assign bus.res_ready = res_ready_c;
  assign cur_data      = res_data_reg;
  assign cur_bytes     = res_bytes_reg;
  assign cur_last      = last_idx_reg;
  assign out_active    = (out_state_reg == SEND);
`endif

  // Word selection and byte masking shared by both output variants.
  logic [W-1:0]  cur_word;
  logic [31:0]   ocnt_base;

  assign cur_word  = cur_data[(BLOCK_WORDS - 1 - 32'(ocnt_reg)) * W +: W];
  assign ocnt_base = 32'(ocnt_reg) * NB;

  for (gi = 0; gi < NB; gi++) begin : g_out_byte
    assign bus.bdo_valid_bytes[NB-1-gi] = out_active && ((ocnt_base + gi) < 32'(cur_bytes));
    assign bus.bdo[W-1-8*gi -: 8] = bus.bdo_valid_bytes[NB-1-gi] ? cur_word[W-1-8*gi -: 8] : 8'h00;
  end

  assign bus.bdo_valid    = out_active;
  assign bus.end_of_block = out_active && (ocnt_reg == cur_last);
endmodule

// File: tb/tb_lwc_block_buffer.sv
// Directed bench for lwc_block_buffer (W=32, BLOCK_WORDS=8): block packing,
// padding, back-pressure, result serialisation, empty result and reset.
module tb_lwc_block_buffer;
  localparam int W  = 32;
  localparam int BW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lwc_block_buffer_if #(.W(W), .BLOCK_WORDS(BW)) bus ();
  lwc_block_buffer #(.W(W), .BLOCK_WORDS(BW), .PAD_BYTE(8'h01)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int compared   = 0;
  int mismatched = 0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [31:0] d, input logic [3:0] m, input logic eot);
    int n = 0;
    bus.bdi = d; bus.bdi_valid_bytes = m; bus.bdi_eot = eot; bus.bdi_valid = 1'b1;
    while (!bus.bdi_ready && n < 20) begin tick(); n++; end
    chk("bdi_ready_wait", 256'(bus.bdi_ready), 256'(1'b1));
    tick();
    bus.bdi_valid = 1'b0; bus.bdi_eot = 1'b0;
  endtask

  task automatic check_block(input string tag, input logic [255:0] data, input logic [5:0] bytes, input logic last);
    chk({tag, "_valid"}, 256'({bus.blk_valid, bus.bdi_ready}), 256'(2'b10));
    chk({tag, "_data"}, bus.blk_data, data);
    chk({tag, "_bytes_last"}, 256'({bus.blk_bytes, bus.blk_last}), 256'({bytes, last}));
    $display("block %s bytes=%0d last=%0b data=%h", tag, bus.blk_bytes, bus.blk_last, bus.blk_data);
  endtask

  task automatic consume_block();
    bus.blk_ready = 1'b1;
    tick();
    bus.blk_ready = 1'b0;
    chk("blk_consumed", {bus.blk_valid, bus.bdi_ready, bus.blk_bytes, bus.blk_data}, {1'b0, 1'b1, 6'd0, 256'd0});
  endtask

  task automatic check_bdo(input string tag, input logic [31:0] d, input logic [3:0] m, input logic eob);
    chk(tag, 256'({bus.bdo_valid, bus.bdo, bus.bdo_valid_bytes, bus.end_of_block}), 256'({1'b1, d, m, eob}));
    $display("bdo %s word=%h mask=%b eob=%0b", tag, bus.bdo, bus.bdo_valid_bytes, bus.end_of_block);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] e;
    logic [255:0] r;
    bus.bdi = '0; bus.bdi_valid = 1'b0; bus.bdi_eot = 1'b0; bus.bdi_valid_bytes = '0;
    bus.blk_ready = 1'b0; bus.res_data = '0; bus.res_bytes = '0; bus.res_valid = 1'b0;
    bus.bdo_ready = 1'b0;

    // Reset state
    tick(); tick();
    rst = 1'b0;
    chk("reset_ready", 256'({bus.bdi_ready, bus.res_ready}), 256'(2'b11));
    chk("reset_valid", 256'({bus.blk_valid, bus.bdo_valid, bus.end_of_block, bus.blk_last}), 256'(0));
    chk("reset_blk", {bus.blk_bytes, bus.blk_data}, 262'(0));

    // 8 full words, eot on the 8th: exactly full block, no pad
    for (int i = 0; i < BW; i++) begin
      chk("t1_no_early_valid", 256'(bus.blk_valid), 256'(1'b0));
      send_word(32'(i + 1), 4'b1111, i == BW - 1);
    end
    check_block("t1", {32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8}, 6'd32, 1'b1);
    consume_block();

    // 3 words, short final word with mask 1100
    send_word(32'h11111111, 4'b1111, 1'b0);
    send_word(32'h22222222, 4'b1111, 1'b0);
    send_word(32'hAABBCCDD, 4'b1100, 1'b1);
    check_block("t2", {32'h11111111, 32'h22222222, 32'hAABB0100, 160'd0}, 6'd10, 1'b1);
    consume_block();

    // 12 words, eot on the 12th, core stalls the first block for 3 cycles
    e = '0;
    for (int i = 0; i < BW; i++) begin
      e[255-32*i -: 32] = 32'hA0000001 + 32'(i);
      send_word(32'hA0000001 + 32'(i), 4'b1111, 1'b0);
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("t3_stall", 256'({bus.blk_valid, bus.bdi_ready}), 256'(2'b10));
    end
    check_block("t3a", e, 6'd32, 1'b0);
    consume_block();
    e = '0;
    for (int i = 0; i < 4; i++) begin
      e[255-32*i -: 32] = 32'hA0000009 + 32'(i);
      send_word(32'hA0000009 + 32'(i), 4'b1111, i == 3);
    end
    e[255-32*4 -: 32] = 32'h01000000;
    check_block("t3b", e, 6'd16, 1'b1);
    consume_block();

    // Result of 10 bytes with a 5-cycle stall on word 1
    r = {32'h11223344, 32'h55667788, 32'h99AABBCC, 32'hDDEEFF00,
         32'h01020304, 32'h05060708, 32'h090A0B0C, 32'h0D0E0F10};
    bus.res_data = r; bus.res_bytes = 6'd10; bus.res_valid = 1'b1; bus.bdo_ready = 1'b1;
    chk("t4_res_ready_idle", 256'(bus.res_ready), 256'(1'b1));
    tick();
    bus.res_valid = 1'b0;
    check_bdo("t4_w0", 32'h11223344, 4'b1111, 1'b0);
`ifndef LWC_OUT_PINGPONG_EN
    chk("t4_res_ready_send", 256'(bus.res_ready), 256'(1'b0));
`endif
    tick();
    bus.bdo_ready = 1'b0;
    check_bdo("t4_w1", 32'h55667788, 4'b1111, 1'b0);
    for (int c = 0; c < 5; c++) begin
      tick();
      check_bdo("t4_w1_hold", 32'h55667788, 4'b1111, 1'b0);
    end
    bus.bdo_ready = 1'b1;
    tick();
    check_bdo("t4_w2", 32'h99AA0000, 4'b1100, 1'b1);
`ifndef LWC_OUT_PINGPONG_EN
    chk("t4_res_ready_last", 256'(bus.res_ready), 256'(1'b0));
`endif
    tick();
    chk("t4_done", 256'({bus.bdo_valid, bus.end_of_block, bus.bdo_valid_bytes, bus.bdo, bus.res_ready}),
        256'({1'b0, 1'b0, 4'b0000, 32'd0, 1'b1}));
    bus.bdo_ready = 1'b0;

    // Empty result is consumed without output
    bus.res_bytes = 6'd0; bus.res_valid = 1'b1;
    tick();
    bus.res_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk("t5_empty", 256'({bus.bdo_valid, bus.res_ready}), 256'(2'b01));
      tick();
    end

    // Reset after 4 input words discards the partial block
    for (int i = 0; i < 4; i++) send_word(32'hE0000000 + 32'(i), 4'b1111, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk("t6_after_rst", {bus.blk_valid, bus.bdi_ready, bus.blk_bytes, bus.blk_data}, {1'b0, 1'b1, 6'd0, 256'd0});
      tick();
    end
    e = '0;
    for (int i = 0; i < BW; i++) begin
      e[255-32*i -: 32] = 32'h50000000 + 32'(i);
      send_word(32'h50000000 + 32'(i), 4'b1111, 1'b0);
    end
    check_block("t6", e, 6'd32, 1'b0);
    consume_block();

`ifdef LWC_OUT_PINGPONG_EN
    // Two back-to-back 32-byte results stream with no gap
    for (int i = 0; i < BW; i++) r[255-32*i -: 32] = 32'hC0DE0000 + 32'(i);
    bus.res_data = r; bus.res_bytes = 6'd32; bus.res_valid = 1'b1; bus.bdo_ready = 1'b1;
    tick();
    for (int i = 0; i < BW; i++) r[255-32*i -: 32] = 32'hBEEF0000 + 32'(i);
    bus.res_data = r;
    chk("pp_res_ready", 256'(bus.res_ready), 256'(1'b1));
    for (int k = 0; k < 16; k++) begin
      check_bdo("pp_word", (k < 8) ? 32'hC0DE0000 + 32'(k) : 32'hBEEF0000 + 32'(k - 8), 4'b1111, (k % 8) == 7);
      tick();
      if (k == 0) bus.res_valid = 1'b0;
    end
    chk("pp_done", 256'(bus.bdo_valid), 256'(1'b0));
    bus.bdo_ready = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
